pwm_decoder: RTL

- Measures the high time of an incoming servo-style PWM line and recovers the signed 8-bit wheel command that produced it.
- It is the inverse of pwm_converter and uses the same parameter set and scaling.
- Used for RC-receiver input, and for loopback checking of pwm_converter outputs alongside bangbang_controller.

---
 rtl/pwm_decoder.sv | 132 +++++++++++++
 1 files changed

// File: rtl/pwm_decoder.sv
// Servo-style PWM decoder: measures the synchronized high time in percent units
// and turns it back into the signed 8-bit wheel command that produced it.
module pwm_decoder #(
    parameter logic       FLIPPED        = 1'b0,
    parameter logic [6:0] ZERO           = 7'd60,
    parameter int         PERIOD         = 100,
    parameter int         ONE_PCT_PERIOD = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              one_MHz_enable,
    input  logic              wheel_signal,
    output logic signed [7:0] wheel_cmd,
    output logic              cmd_valid,
    output logic              signal_lost
);

    typedef enum logic [1:0] {WAIT_LOW, WAIT_RISE, MEASURE, DECODE} state_t;

    localparam int         PRESC_W    = 16;
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(ONE_PCT_PERIOD - 1);
    localparam logic [8:0] PERIOD_W   = 9'(PERIOD);
    localparam logic [9:0] TIMEOUT_W  = 10'(2 * PERIOD);
    localparam logic [8:0] CNT_MAX    = 9'd511;

    state_t               state_q, state_d;
    logic                 sync1_q, s_q, s_prev_q, settled_q;
    logic [PRESC_W-1:0]   presc_q, presc_d;
    logic [8:0]           width_q, width_d;
    logic [8:0]           idle_q, idle_d;
    logic signed [7:0]    cmd_q, cmd_d;
    logic                 valid_q, valid_d;
    logic                 lost_q, lost_d;
    logic                 tick, rise, fall;

    function automatic logic signed [7:0] decode_cmd(input logic [8:0] w);
        logic signed [9:0] d;
        d = $signed({1'b0, w}) - $signed({3'b000, ZERO});
        if (FLIPPED) d = -d;
        if (d > 10'sd127)       return 8'sd127;
        else if (d < -10'sd127) return -8'sd127;
        else                    return $signed(d[7:0]);
    endfunction

    assign rise = s_q & ~s_prev_q;
    assign fall = ~s_q & s_prev_q;
    assign tick = one_MHz_enable && (presc_q == PRESC_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q   <= 1'b0;
            s_q       <= 1'b0;
            s_prev_q  <= 1'b0;
            settled_q <= 1'b0;
            state_q   <= WAIT_LOW;
            presc_q   <= '0;
            width_q   <= '0;
            idle_q    <= '0;
            cmd_q     <= '0;
            valid_q   <= 1'b0;
            lost_q    <= 1'b1;
        end else begin
            sync1_q   <= wheel_signal;
            s_q       <= sync1_q;
            s_prev_q  <= s_q;
            settled_q <= 1'b1;
            state_q   <= state_d;
            presc_q   <= presc_d;
            width_q   <= width_d;
            idle_q    <= idle_d;
            cmd_q     <= cmd_d;
            valid_q   <= valid_d;
            lost_q    <= lost_d;
        end
    end

    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        width_d = width_q;
        idle_d  = idle_q;
        cmd_d   = cmd_q;
        valid_d = 1'b0;
        lost_d  = lost_q;

        if (one_MHz_enable) presc_d = tick ? '0 : presc_q + 1'b1;

        if (rise || fall)                  idle_d = '0;
        else if (tick && idle_q != CNT_MAX) idle_d = idle_q + 9'd1;

        case (state_q)
            WAIT_LOW: begin
                // The reset values of the synchronizer look like a low line, so
                // wait until the pipe has refilled before trusting s=0.
                if (settled_q && !sync1_q && !s_q) state_d = WAIT_RISE;
            end
            WAIT_RISE: begin
                if (rise) begin
                    width_d = '0;
                    presc_d = '0;
                    state_d = MEASURE;
                end
            end
            MEASURE: begin
                if (tick && width_q != CNT_MAX) width_d = width_q + 9'd1;
                if (width_q > PERIOD_W) begin
                    lost_d  = 1'b1;
                    state_d = WAIT_LOW;
                end else if (fall) begin
                    state_d = DECODE;
                end
            end
            DECODE: begin
                cmd_d   = decode_cmd(width_q);
                valid_d = 1'b1;
                lost_d  = 1'b0;
                state_d = WAIT_RISE;
            end
            default: state_d = WAIT_LOW;
        endcase

        if ((state_q == WAIT_LOW || state_q == WAIT_RISE) && ({1'b0, idle_q} >= TIMEOUT_W)) begin
            lost_d = 1'b1;
            cmd_d  = '0;
        end
    end

    assign wheel_cmd   = cmd_q;
    assign cmd_valid   = valid_q;
    assign signal_lost = lost_q;

endmodule
